// File: rtl/pc_branch_pkg.sv
// ---------------------------------------------------------------------------
// pc_branch_pkg
// Shared constants for the PC / branch control slice:
//   - RV32 conditional-branch funct3 encodings
//   - flush FSM state encoding
//   - flush counter width
// ---------------------------------------------------------------------------
package pc_branch_pkg;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   // Flush counter width; FLUSH_CYCLES is limited to 1..15.
   localparam int FLUSH_CNT_W = 4;

endpackage

// File: rtl/pc_branch_cond_decode.sv
// ---------------------------------------------------------------------------
// branch_cond_decode
// Purely combinational decode of a conditional branch.
// Ports:
//   funct3  in  3  branch funct3 field
//   BrEq    in  1  equality result from branch_comp
//   BrLT    in  1  less-than result from branch_comp
//   taken   out 1  branch condition satisfied
//   BrUn    out 1  comparator mode request, 1 = unsigned
//   illegal out 1  funct3 is 010 or 011 (no such branch)
// ---------------------------------------------------------------------------
module branch_cond_decode
   import pc_branch_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       BrEq,
   input  logic       BrLT,
   output logic       taken,
   output logic       BrUn,
   output logic       illegal
);

   // funct3[1] selects the unsigned variants (BLTU/BGEU); the comparator
   // needs it even before br_valid is known, so it is not gated.
   assign BrUn = funct3[1];

   always_comb begin
      taken   = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3_BEQ:  taken = BrEq;
         F3_BNE:  taken = !BrEq;
         F3_BLT:  taken = BrLT;
         F3_BGE:  taken = !BrLT;
         F3_BLTU: taken = BrLT;
         F3_BGEU: taken = !BrLT;
         default: illegal = 1'b1;   // 010 / 011
      endcase
   end

endmodule

// File: rtl/pc_branch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_branch_ctrl
// Owns the architectural PC, resolves branches from branch_comp results and
// squashes younger instructions after a redirect via a small flush FSM.
// Optional build macro: BRANCH_STATS_EN adds branch / taken-branch counters.
// Ports:
//   clk, rst             clock (rising edge), async active-high reset
//   stall                hold PC and FSM
//   br_valid, jump       current instruction is a branch / JAL(R)
//   funct3, BrEq, BrLT   branch decode inputs
//   BrUn                 unsigned compare request to branch_comp
//   target               branch/jump target
//   pc, pc_plus4         current PC (registered) and pc + 4
//   redirect             PC loads target at next edge
//   flush                registered squash of IF/ID
//   illegal_br           branch with reserved funct3
//   misalign             redirect to a target with bit 1 set
//   br_count, br_taken_count   (BRANCH_STATS_EN only) statistics
// ---------------------------------------------------------------------------
module pc_branch_ctrl
   import pc_branch_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            br_valid,
   input  logic            jump,
   input  logic [2:0]      funct3,
   input  logic            BrEq,
   input  logic            BrLT,
   output logic            BrUn,
   input  logic [XLEN-1:0] target,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            redirect,
   output logic            flush,
   output logic            illegal_br,
   output logic            misalign
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     br_count,
   output logic [31:0]     br_taken_count
`endif
);

   localparam logic [FLUSH_CNT_W-1:0] CNT_INIT = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   logic [XLEN-1:0]        pcReg, pcNext;
   logic [0:0]             stateReg, stateNext;
   logic [FLUSH_CNT_W-1:0] cntReg, cntNext;
   logic                   flushReg, flushNext;
   logic                   decTaken, decIllegal;
   logic                   inIdle;

   branch_cond_decode uDecode (
      .funct3  (funct3),
      .BrEq    (BrEq),
      .BrLT    (BrLT),
      .taken   (decTaken),
      .BrUn    (BrUn),
      .illegal (decIllegal)
   );

   assign inIdle   = (stateReg == S_IDLE);
   assign pc       = pcReg;
   assign pc_plus4 = pcReg + XLEN'(4);
   assign flush    = flushReg;

   // A reserved funct3 never resolves as taken, so no extra gating is
   // needed here; jump takes priority over any branch decode.
   assign redirect   = inIdle & !stall & (jump | (br_valid & decTaken));
   assign illegal_br = br_valid & !jump & decIllegal;
   assign misalign   = redirect & target[1];

   // Bit 0 is always cleared (JALR semantics); bit 1 is kept even when it
   // makes the PC misaligned -- misalign only reports it.
   always_comb begin
      pcNext = pc_plus4;
      if (redirect)
         pcNext = {target[XLEN-1:1], 1'b0};
      else if (stall)
         pcNext = pcReg;
   end

   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      flushNext = flushReg;
      if (stateReg == S_IDLE) begin
         if (redirect) begin
            stateNext = S_FLUSH;
            cntNext   = CNT_INIT;
            flushNext = 1'b1;
         end
      end else if (!stall) begin
         // Stall freezes both counter and flush in this state.
         if (cntReg == '0) begin
            stateNext = S_IDLE;
            flushNext = 1'b0;
         end else begin
            cntNext = cntReg - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pcReg    <= RESET_PC;
         stateReg <= S_IDLE;
         cntReg   <= '0;
         flushReg <= 1'b0;
      end else begin
         pcReg    <= pcNext;
         stateReg <= stateNext;
         cntReg   <= cntNext;
         flushReg <= flushNext;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] brCountReg, brTakenCountReg;
   logic        brCountable;

   // Only branches that are actually evaluated (IDLE, not stalled) count.
   assign brCountable = inIdle & !stall & br_valid & !decIllegal;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         brCountReg      <= '0;
         brTakenCountReg <= '0;
      end else begin
         if (brCountable)
            brCountReg <= brCountReg + 32'd1;
         if (brCountable & decTaken)
            brTakenCountReg <= brTakenCountReg + 32'd1;
      end
   end

   assign br_count       = brCountReg;
   assign br_taken_count = brTakenCountReg;
`endif

endmodule

// File: tb/tb_pc_branch_ctrl.sv
module tb_pc_branch_ctrl;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        br_valid;
   logic        jump;
   logic [2:0]  funct3;
   logic        BrEq;
   logic        BrLT;
   logic        BrUn;
   logic [31:0] target;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        redirect;
   logic        flush;
   logic        illegal_br;
   logic        misalign;
`ifdef BRANCH_STATS_EN
   logic [31:0] br_count;
   logic [31:0] br_taken_count;
`endif

   int nCompared   = 0;
   int nMismatched = 0;

   pc_branch_ctrl #(
      .XLEN         (32),
      .RESET_PC     (32'h0000_0100),
      .FLUSH_CYCLES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .stall      (stall),
      .br_valid   (br_valid),
      .jump       (jump),
      .funct3     (funct3),
      .BrEq       (BrEq),
      .BrLT       (BrLT),
      .BrUn       (BrUn),
      .target     (target),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .redirect   (redirect),
      .flush      (flush),
      .illegal_br (illegal_br),
      .misalign   (misalign)
`ifdef BRANCH_STATS_EN
      ,
      .br_count       (br_count),
      .br_taken_count (br_taken_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 0; br_valid = 0; jump = 0; funct3 = 3'b000;
      BrEq = 0; BrLT = 0; target = 32'h0;
      #2;
      nCompared++; if (pc !== 32'h100) begin nMismatched++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h100); end
      nCompared++; if (flush !== 1'b0) begin nMismatched++; $display("FAIL reset_flush: got %b expected %b", flush, 1'b0); end
      tick();
      rst = 1'b0;
      #1;
      nCompared++; if (pc_plus4 !== 32'h104) begin nMismatched++; $display("FAIL reset_pcp4: got %h expected %h", pc_plus4, 32'h104); end
      tick();
      nCompared++; if (pc !== 32'h104) begin nMismatched++; $display("FAIL run_pc1: got %h expected %h", pc, 32'h104); end
      tick();
      nCompared++; if (pc !== 32'h108) begin nMismatched++; $display("FAIL run_pc2: got %h expected %h", pc, 32'h108); end
      $display("test_reset: pc=%h flush=%b", pc, flush);
   endtask

   task automatic test_blt_taken();
      br_valid = 1; funct3 = 3'b100; BrLT = 1; BrEq = 0; target = 32'h200;
      #1;
      nCompared++; if (BrUn !== 1'b0) begin nMismatched++; $display("FAIL blt_brun: got %b expected %b", BrUn, 1'b0); end
      nCompared++; if (redirect !== 1'b1) begin nMismatched++; $display("FAIL blt_redirect: got %b expected %b", redirect, 1'b1); end
      tick();
      nCompared++; if (pc !== 32'h200) begin nMismatched++; $display("FAIL blt_pc: got %h expected %h", pc, 32'h200); end
      nCompared++; if (flush !== 1'b1) begin nMismatched++; $display("FAIL blt_flush1: got %b expected %b", flush, 1'b1); end
      nCompared++; if (redirect !== 1'b0) begin nMismatched++; $display("FAIL blt_ignored1: got %b expected %b", redirect, 1'b0); end
      tick();
      nCompared++; if (pc !== 32'h204) begin nMismatched++; $display("FAIL blt_pc2: got %h expected %h", pc, 32'h204); end
      nCompared++; if (flush !== 1'b1) begin nMismatched++; $display("FAIL blt_flush2: got %b expected %b", flush, 1'b1); end
      nCompared++; if (redirect !== 1'b0) begin nMismatched++; $display("FAIL blt_ignored2: got %b expected %b", redirect, 1'b0); end
      tick();
      br_valid = 0;
      nCompared++; if (pc !== 32'h208) begin nMismatched++; $display("FAIL blt_pc3: got %h expected %h", pc, 32'h208); end
      nCompared++; if (flush !== 1'b0) begin nMismatched++; $display("FAIL blt_flush_end: got %b expected %b", flush, 1'b0); end
      $display("test_blt_taken: pc=%h flush=%b", pc, flush);
   endtask

   task automatic test_not_taken();
      br_valid = 1; funct3 = 3'b111; BrLT = 1; BrEq = 0; target = 32'h600;
      #1;
      nCompared++; if (BrUn !== 1'b1) begin nMismatched++; $display("FAIL bgeu_brun: got %b expected %b", BrUn, 1'b1); end
      nCompared++; if (redirect !== 1'b0) begin nMismatched++; $display("FAIL bgeu_redirect: got %b expected %b", redirect, 1'b0); end
      tick();
      nCompared++; if (pc !== 32'h20C) begin nMismatched++; $display("FAIL bgeu_pc: got %h expected %h", pc, 32'h20C); end
      funct3 = 3'b001; BrEq = 1; BrLT = 0;
      #1;
      nCompared++; if (redirect !== 1'b0) begin nMismatched++; $display("FAIL bne_redirect: got %b expected %b", redirect, 1'b0); end
      nCompared++; if (BrUn !== 1'b0) begin nMismatched++; $display("FAIL bne_brun: got %b expected %b", BrUn, 1'b0); end
      tick();
      br_valid = 0;
      nCompared++; if (pc !== 32'h210) begin nMismatched++; $display("FAIL bne_pc: got %h expected %h", pc, 32'h210); end
      nCompared++; if (flush !== 1'b0) begin nMismatched++; $display("FAIL bne_flush: got %b expected %b", flush, 1'b0); end
`ifdef BRANCH_STATS_EN
      nCompared++; if (br_count !== 32'd3) begin nMismatched++; $display("FAIL stats_count: got %0d expected %0d", br_count, 3); end
      nCompared++; if (br_taken_count !== 32'd1) begin nMismatched++; $display("FAIL stats_taken: got %0d expected %0d", br_taken_count, 1); end
`endif
      $display("test_not_taken: pc=%h", pc);
   endtask

   task automatic test_stall();
      br_valid = 1; funct3 = 3'b000; BrEq = 1; BrLT = 0; target = 32'h400; stall = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         nCompared++; if (redirect !== 1'b0) begin nMismatched++; $display("FAIL stall_redirect%0d: got %b expected %b", i, redirect, 1'b0); end
         tick();
         nCompared++; if (pc !== 32'h210) begin nMismatched++; $display("FAIL stall_pc%0d: got %h expected %h", i, pc, 32'h210); end
      end
      stall = 0;
      #1;
      nCompared++; if (redirect !== 1'b1) begin nMismatched++; $display("FAIL unstall_redirect: got %b expected %b", redirect, 1'b1); end
      tick();
      br_valid = 0;
      nCompared++; if (pc !== 32'h400) begin nMismatched++; $display("FAIL unstall_pc: got %h expected %h", pc, 32'h400); end
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         nCompared++; if (pc !== 32'h400) begin nMismatched++; $display("FAIL fstall_pc%0d: got %h expected %h", i, pc, 32'h400); end
         nCompared++; if (flush !== 1'b1) begin nMismatched++; $display("FAIL fstall_flush%0d: got %b expected %b", i, flush, 1'b1); end
      end
      stall = 0;
      tick();
      nCompared++; if (pc !== 32'h404) begin nMismatched++; $display("FAIL fstall_pc_a: got %h expected %h", pc, 32'h404); end
      nCompared++; if (flush !== 1'b1) begin nMismatched++; $display("FAIL fstall_flush_a: got %b expected %b", flush, 1'b1); end
      tick();
      nCompared++; if (pc !== 32'h408) begin nMismatched++; $display("FAIL fstall_pc_b: got %h expected %h", pc, 32'h408); end
      nCompared++; if (flush !== 1'b0) begin nMismatched++; $display("FAIL fstall_flush_b: got %b expected %b", flush, 1'b0); end
      $display("test_stall: pc=%h flush=%b", pc, flush);
   endtask

   task automatic test_jump_misalign();
      jump = 1; target = 32'h301;
      #1;
      nCompared++; if (redirect !== 1'b1) begin nMismatched++; $display("FAIL jalr_redirect: got %b expected %b", redirect, 1'b1); end
      nCompared++; if (misalign !== 1'b0) begin nMismatched++; $display("FAIL jalr_misalign0: got %b expected %b", misalign, 1'b0); end
      tick();
      jump = 0;
      nCompared++; if (pc !== 32'h300) begin nMismatched++; $display("FAIL jalr_pc: got %h expected %h", pc, 32'h300); end
      tick();
      tick();
      nCompared++; if (pc !== 32'h308) begin nMismatched++; $display("FAIL jalr_pc2: got %h expected %h", pc, 32'h308); end
      jump = 1; target = 32'h302;
      #1;
      nCompared++; if (misalign !== 1'b1) begin nMismatched++; $display("FAIL jalr_misalign1: got %b expected %b", misalign, 1'b1); end
      tick();
      jump = 0;
      nCompared++; if (pc !== 32'h302) begin nMismatched++; $display("FAIL jalr_pc_mis: got %h expected %h", pc, 32'h302); end
      tick();
      tick();
      nCompared++; if (pc !== 32'h30A) begin nMismatched++; $display("FAIL jalr_pc3: got %h expected %h", pc, 32'h30A); end
      br_valid = 1; funct3 = 3'b010; BrEq = 1; BrLT = 1; target = 32'h700;
      #1;
      nCompared++; if (illegal_br !== 1'b1) begin nMismatched++; $display("FAIL illegal_010: got %b expected %b", illegal_br, 1'b1); end
      nCompared++; if (redirect !== 1'b0) begin nMismatched++; $display("FAIL illegal_redirect: got %b expected %b", redirect, 1'b0); end
      funct3 = 3'b011;
      #1;
      nCompared++; if (illegal_br !== 1'b1) begin nMismatched++; $display("FAIL illegal_011: got %b expected %b", illegal_br, 1'b1); end
      jump = 1;
      #1;
      nCompared++; if (illegal_br !== 1'b0) begin nMismatched++; $display("FAIL jump_wins_illegal: got %b expected %b", illegal_br, 1'b0); end
      nCompared++; if (redirect !== 1'b1) begin nMismatched++; $display("FAIL jump_wins_redirect: got %b expected %b", redirect, 1'b1); end
      jump = 0;
      tick();
      nCompared++; if (pc !== 32'h30E) begin nMismatched++; $display("FAIL illegal_pc: got %h expected %h", pc, 32'h30E); end
      br_valid = 0;
      #1;
      nCompared++; if (illegal_br !== 1'b0) begin nMismatched++; $display("FAIL illegal_clear: got %b expected %b", illegal_br, 1'b0); end
      $display("test_jump_misalign: pc=%h", pc);
   endtask

   task automatic test_async_reset();
      br_valid = 1; funct3 = 3'b000; BrEq = 1; BrLT = 0; target = 32'h500;
      tick();
      br_valid = 0;
      nCompared++; if (pc !== 32'h500) begin nMismatched++; $display("FAIL ar_pc_pre: got %h expected %h", pc, 32'h500); end
      nCompared++; if (flush !== 1'b1) begin nMismatched++; $display("FAIL ar_flush_pre: got %b expected %b", flush, 1'b1); end
      #1;
      rst = 1'b1;
      #1;
      nCompared++; if (flush !== 1'b0) begin nMismatched++; $display("FAIL ar_flush: got %b expected %b", flush, 1'b0); end
      nCompared++; if (pc !== 32'h100) begin nMismatched++; $display("FAIL ar_pc: got %h expected %h", pc, 32'h100); end
      tick();
      rst = 1'b0;
      tick();
      nCompared++; if (pc !== 32'h104) begin nMismatched++; $display("FAIL ar_pc_run: got %h expected %h", pc, 32'h104); end
      nCompared++; if (flush !== 1'b0) begin nMismatched++; $display("FAIL ar_flush_run: got %b expected %b", flush, 1'b0); end
      $display("test_async_reset: pc=%h flush=%b", pc, flush);
   endtask

   initial begin
      test_reset();
      test_blt_taken();
      test_not_taken();
      test_stall();
      test_jump_misalign();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
